// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Holds the program counter, drives a single-outstanding request/ready instruction-memory
// port and fills the IF/ID register consumed by decode. A one-entry skid buffer absorbs a
// word that returns while decode is stalled. Taken branches and jumps redirect the PC.
// A fetch that is still in flight at redirect time is drained and its word discarded.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   stall                        decode cannot accept; IF/ID holds
//   branch_taken, branch_target  taken-branch redirect from decode
//   jump, jump_target            j/jal redirect from decode (wins over branch)
//   imem_req, imem_addr          fetch request and word address
//   imem_ready, imem_rdata       memory response; transfer = imem_req & imem_ready
//   instruction, pc_plus4        IF/ID register contents
//   id_valid                     IF/ID holds a real instruction
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        id_valid
);

  typedef enum logic [1:0] {StBoot, StFetch, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = branch_taken | jump;
  assign target   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
  assign pc_inc   = pc_q + 32'd4;

  // In DRAIN the request must keep presenting the address that was outstanding at redirect.
  assign imem_req    = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr   = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign instruction = instr_q;
  assign pc_plus4    = pc_plus4_q;
  assign id_valid    = id_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    id_valid_d   = id_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    drain_addr_d = drain_addr_q;

    case (state_q)
      StBoot: begin
        state_d = StFetch;
      end

      StFetch: begin
        drain_addr_d = pc_q;
        if (redirect) begin
          // Flush wins over stall; a word arriving this cycle is dropped.
          pc_d       = target;
          instr_d    = 32'h0;
          id_valid_d = 1'b0;
          if (!imem_ready) begin
            state_d = StDrain;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (!stall) begin
            instr_d    = imem_rdata;
            pc_plus4_d = pc_inc;
            id_valid_d = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_inc;
            state_d      = StHold;
          end
        end else if (!stall) begin
          instr_d    = 32'h0;
          id_valid_d = 1'b0;
        end
      end

      StDrain: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ready) begin
          state_d = StFetch;
        end
      end

      StHold: begin
        if (redirect) begin
          pc_d       = target;
          instr_d    = 32'h0;
          id_valid_d = 1'b0;
          state_d    = StFetch;
        end else if (!stall) begin
          instr_d    = skid_instr_q;
          pc_plus4_d = skid_pc4_q;
          id_valid_d = 1'b1;
          state_d    = StFetch;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      pc_plus4_q   <= 32'h0;
      id_valid_q   <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      id_valid_q   <= id_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      drain_addr_q <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. Memory returns word == address. A negedge scoreboard keeps an
// independent expected PC: each accepted fetch pushes {word, addr+4}, each instruction decode
// consumes (id_valid & !stall) pops and compares, and every redirect discards what is queued.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        id_valid;

  int checks;
  int errors;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_plus4     (pc_plus4),
    .id_valid     (id_valid)
  );

  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc4_q[$];
  logic [31:0] exp_pc;
  logic [31:0] drain_addr;
  logic        draining;

  always @(negedge clk) begin
    logic [31:0] tgt;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        redir;
    if (!rst_n) begin
      exp_instr_q.delete();
      exp_pc4_q.delete();
      exp_pc   = 32'h0;
      draining = 1'b0;
    end else begin
      redir = branch_taken | jump;
      tgt   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
      if (id_valid && !stall) begin
        checks++;
        if (exp_instr_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got instr %h pc_plus4 %h, expected nothing queued",
                   instruction, pc_plus4);
        end else begin
          ei = exp_instr_q.pop_front();
          ep = exp_pc4_q.pop_front();
          if (instruction !== ei || pc_plus4 !== ep) begin
            errors++;
            $display("FAIL sb_ifid: got instr %h pc_plus4 %h, expected instr %h pc_plus4 %h",
                     instruction, pc_plus4, ei, ep);
          end
        end
      end
      if (imem_req && imem_ready) begin
        checks++;
        if (imem_addr !== (draining ? drain_addr : exp_pc)) begin
          errors++;
          $display("FAIL sb_addr: got %h, expected %h", imem_addr,
                   draining ? drain_addr : exp_pc);
        end
        if (draining) begin
          draining = 1'b0;
        end else if (!redir) begin
          exp_instr_q.push_back(exp_pc);
          exp_pc4_q.push_back(exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redir) begin
        exp_instr_q.delete();
        exp_pc4_q.delete();
        if (imem_req && !imem_ready && !draining) begin
          draining   = 1'b1;
          drain_addr = exp_pc;
        end
        exp_pc = tgt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n;
    n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_addr: timed out, got %h, expected %h", imem_addr, a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || instruction !== 32'h0 || pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: got req %b valid %b instr %h pc4 %h, expected 0 0 0 0",
               imem_req, id_valid, instruction, pc_plus4);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_req: got %b, expected 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: got req %b addr %h valid %b, expected 1 0 0",
               imem_req, imem_addr, id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || instruction !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL stream_%0d: got valid %b instr %h pc4 %h, expected 1 %h %h", i,
                 id_valid, instruction, pc_plus4, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    wait_addr(32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || instruction !== 32'hC || pc_plus4 !== 32'h10) begin
        errors++;
        $display("FAIL stall_hold_%0d: got req %b instr %h pc4 %h, expected 0 c 10", i,
                 imem_req, instruction, pc_plus4);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (id_valid !== 1'b1 || instruction !== 32'h10 || pc_plus4 !== 32'h14 ||
        imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: got valid %b instr %h pc4 %h addr %h, expected 1 10 14 14",
               id_valid, instruction, pc_plus4, imem_addr);
    end
  endtask

  task automatic test_drain();
    wait_addr(32'h20);
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_wait1: got req %b addr %h valid %b, expected 1 20 0",
               imem_req, imem_addr, id_valid);
    end
    step();
    checks++;
    if (imem_addr !== 32'h20) begin
      errors++;
      $display("FAIL drain_wait2: got addr %h, expected 20", imem_addr);
    end
    imem_ready = 1'b1;
    step();
    checks++;
    if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: got addr %h valid %b, expected 100 0", imem_addr, id_valid);
    end
    step();
    checks++;
    if (instruction !== 32'h100 || pc_plus4 !== 32'h104 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_target: got instr %h pc4 %h valid %b, expected 100 104 1",
               instruction, pc_plus4, id_valid);
    end
  endtask

  task automatic test_jump_priority();
    jump          = 1'b1;
    jump_target   = 32'h203;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (imem_addr !== 32'h200 || id_valid !== 1'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL jump_prio: got addr %h valid %b instr %h, expected 200 0 0",
               imem_addr, id_valid, instruction);
    end
    step();
    checks++;
    if (instruction !== 32'h200 || pc_plus4 !== 32'h204) begin
      errors++;
      $display("FAIL jump_word: got instr %h pc4 %h, expected 200 204", instruction, pc_plus4);
    end
  endtask

  task automatic test_hold_redirect_wrap();
    stall = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_req: got %b, expected 0", imem_req);
    end
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL hold_redirect: got valid %b req %b addr %h, expected 0 1 fffffffc",
               id_valid, imem_req, imem_addr);
    end
    stall = 1'b0;
    step();
    checks++;
    if (instruction !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || imem_addr !== 32'h0 ||
        id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got instr %h pc4 %h addr %h valid %b, expected fffffffc 0 0 1",
               instruction, pc_plus4, imem_addr, id_valid);
    end
    step();
    checks++;
    if (instruction !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL after_wrap: got instr %h pc4 %h, expected 0 4", instruction, pc_plus4);
    end
  endtask

  task automatic test_reset_drain();
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h400;
    step();
    branch_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL rd_drain: got req %b addr %h, expected 1 4", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || instruction !== 32'h0 || pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL rd_async: got req %b valid %b instr %h pc4 %h, expected 0 0 0 0",
               imem_req, id_valid, instruction, pc_plus4);
    end
    imem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_boot: got req %b, expected 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_restart: got req %b addr %h valid %b, expected 1 0 0",
               imem_req, imem_addr, id_valid);
    end
    step();
    checks++;
    if (instruction !== 32'h0 || pc_plus4 !== 32'h4 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_first: got instr %h pc4 %h valid %b, expected 0 4 1",
               instruction, pc_plus4, id_valid);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    imem_ready    = 1'b1;
    test_reset();
    test_stall();
    test_drain();
    test_jump_priority();
    test_hold_redirect_wrap();
    test_reset_drain();
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction fetch stage feeding the decode stage. Holds the program counter and drives a single-outstanding request/ready instruction-memory port. Drives the IF/ID pipeline register: the instruction and PC+4 that decode consumes for operand read and branch-target computation. Handles decode stalls with a one-entry skid buffer and taken-branch/jump redirects, including discarding an in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  decode cannot accept; IF/ID register must hold.
branch_taken  input  1  decode resolved a taken branch this cycle.
branch_target  input  32  branch destination address.
jump  input  1  decode issuing j/jal this cycle.
jump_target  input  32  jump destination address.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
imem_ready  input  1  memory returns imem_rdata this cycle; transfer = imem_req & imem_ready.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  IF/ID instruction to decode.
pc_plus4  output  32  IF/ID PC+4 of that instruction.
id_valid  output  1  IF/ID contents are a real instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; instruction=0 (NOP); pc_plus4=0; id_valid=0; imem_req=0; skid empty; state=BOOT. Applies mid-request: pending fetch is abandoned, and a late imem_ready is ignored while in BOOT.
- redirect = branch_taken | jump. Target: jump_target if jump, else branch_target (jump has priority). Bits [1:0] of the target are forced to 0.
- State BOOT: imem_req=0; next cycle -> FETCH.
- State FETCH: imem_req=1; imem_addr=pc.
  - Transfer and redirect: drop the word; pc<=target; IF/ID flushed (instruction=0, id_valid=0); stay FETCH.
  - Transfer, no redirect, stall=0: instruction<=imem_rdata; pc_plus4<=pc+4; id_valid<=1; pc<=pc+4; stay FETCH.
  - Transfer, no redirect, stall=1: IF/ID holds; skid<={imem_rdata, pc+4}; pc<=pc+4; -> HOLD.
  - No transfer, redirect: imem_addr must stay stable; pc<=target; IF/ID flushed; -> DRAIN.
  - No transfer, no redirect: IF/ID loads NOP with id_valid=0 if stall=0, else holds; stay FETCH.
- State DRAIN: imem_req=1; imem_addr=old address (registered). On ready, drop the word -> FETCH at the new pc. Another redirect in DRAIN updates pc only.
- State HOLD: imem_req=0.
  - Redirect: discard skid; pc<=target; flush IF/ID; -> FETCH.
  - stall=0: IF/ID<=skid; id_valid<=1; -> FETCH.
  - stall=1: hold.
- Flush overrides stall: on redirect, the IF/ID register is flushed even when stall=1.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: with ready tied high, an instruction appears in IF/ID one cycle after its request; throughput is one per cycle. The first valid instruction appears 2 cycles after rst_n deassertion.

Test Plan:
- Reset release, RESET_PC=0, ready=1, memory word[n]=n -> imem_addr 0,4,8...; id_valid rises at cycle 2 with instruction=0 and pc_plus4=4, then pc_plus4=8, 12 on consecutive cycles.
- stall=1 for 3 cycles while fetching at 0x10 -> skid captures word 0x10 and imem_req drops; after release, IF/ID shows word 0x10 and pc_plus4=0x14 with no word lost or duplicated.
- ready held low 2 cycles at addr 0x20, branch_taken with target 0x100 in the first wait cycle -> imem_addr stays 0x20 until ready; word 0x20 is never in IF/ID; next request is 0x100.
- jump and branch_taken in the same cycle (targets 0x200 and 0x300), target 0x203 -> next fetch is 0x200; IF/ID flushed with id_valid=0.
- redirect while stall=1 in HOLD -> skid discarded, id_valid=0, fetch from the target; PC at 0xFFFFFFFC with ready=1 -> pc_plus4=0, next address 0.
- rst_n pulsed low while DRAIN is pending -> outputs return to reset values immediately; a late imem_ready has no effect; fetch restarts at RESET_PC.
